// File: rtl/stage1_decode.sv
// Operand-select/decode stage ahead of the ALU: 1-cycle latency from accept to out_valid when empty.
// Backpressure: output + skid register absorb a stall; in_ready is registered (~skid full). Optional STAGE1_STATS_EN adds counters.
module stage1_decode #(
    parameter int DW  = 32,
    parameter int SHW = 5
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           flush,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [31:0]    instr,
    input  logic [DW-1:0]  src1,
    input  logic [DW-1:0]  src2,
    input  logic [DW-1:0]  mem_data,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [DW-1:0]  aluin1,
    output logic [DW-1:0]  aluin2,
    output logic [2:0]     operation,
    output logic [2:0]     opselect,
    output logic [SHW-1:0] shift_number,
    output logic           enable_arith,
    output logic           enable_shift
`ifdef STAGE1_STATS_EN
    ,
    output logic [31:0]    issue_count,
    output logic [31:0]    stall_count
`endif
);

    localparam logic [2:0] OP_SHIFT_REG   = 3'b000;
    localparam logic [2:0] OP_ARITH_LOGIC = 3'b001;
    localparam logic [2:0] OP_MEM_WRITE   = 3'b100;
    localparam logic [2:0] OP_MEM_READ    = 3'b101;

    typedef struct packed {
        logic [DW-1:0]  aluin1;
        logic [DW-1:0]  aluin2;
        logic [2:0]     operation;
        logic [2:0]     opselect;
        logic [SHW-1:0] shamt;
        logic           en_arith;
        logic           en_shift;
    } entry_t;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_e;

    state_e state_q, state_d;
    entry_t out_q, out_d;
    entry_t skid_q, skid_d;
    entry_t dec;
    logic   in_fire;
    logic   out_fire;
    logic   imm_sel;
    logic   unused_instr;

    assign unused_instr = ^{instr[15:12], OP_MEM_WRITE};
    assign imm_sel      = instr[6];

    always_comb begin
        dec           = '0;
        dec.aluin1    = src1;
        dec.operation = instr[2:0];
        dec.opselect  = instr[5:3];
        if (instr[5:3] == OP_MEM_READ) begin
            dec.aluin2 = mem_data;
        end else if (imm_sel) begin
            dec.aluin2 = {{(DW-16){instr[31]}}, instr[31:16]};
        end else begin
            dec.aluin2 = src2;
        end
        dec.shamt    = imm_sel ? SHW'(instr[11:7]) : src2[SHW-1:0];
        dec.en_shift = (instr[5:3] == OP_SHIFT_REG);
        dec.en_arith = (instr[5:3] == OP_ARITH_LOGIC) || (instr[5:3] == OP_MEM_READ);
    end

    assign in_ready  = (state_q != S_FULL);
    assign out_valid = (state_q != S_EMPTY);
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        skid_d  = skid_q;
        // Flush only clears occupancy; held data is left as is.
        if (flush) begin
            state_d = S_EMPTY;
        end else begin
            case (state_q)
                S_EMPTY: begin
                    if (in_fire) begin
                        out_d   = dec;
                        state_d = S_ONE;
                    end
                end
                S_ONE: begin
                    if (in_fire && out_fire) begin
                        out_d = dec;
                    end else if (in_fire) begin
                        skid_d  = dec;
                        state_d = S_FULL;
                    end else if (out_fire) begin
                        state_d = S_EMPTY;
                    end
                end
                S_FULL: begin
                    if (out_fire) begin
                        out_d   = skid_q;
                        state_d = S_ONE;
                    end
                end
                default: state_d = S_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_EMPTY;
            out_q   <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            skid_q  <= skid_d;
        end
    end

    assign aluin1       = out_q.aluin1;
    assign aluin2       = out_q.aluin2;
    assign operation    = out_q.operation;
    assign opselect     = out_q.opselect;
    assign shift_number = out_q.shamt;
    assign enable_arith = out_q.en_arith & out_valid;
    assign enable_shift = out_q.en_shift & out_valid;

`ifdef STAGE1_STATS_EN
    logic [31:0] issue_count_q, issue_count_d;
    logic [31:0] stall_count_q, stall_count_d;

    // Counters survive flush and wrap naturally at 32 bits.
    always_comb begin
        issue_count_d = issue_count_q + {31'd0, out_fire};
        stall_count_d = stall_count_q + {31'd0, out_valid & ~out_ready};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            issue_count_q <= '0;
            stall_count_q <= '0;
        end else begin
            issue_count_q <= issue_count_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign issue_count = issue_count_q;
    assign stall_count = stall_count_q;
`endif

endmodule

// File: doc/stage1_decode.md
Name: stage1_decode

Overview:
- Operand-select / decode stage directly upstream of the ALU stage.
- Accepts one instruction word plus its register-file operands and memory data through a valid/ready handshake.
- Decodes opselect/operation, selects the ALU operands and shift amount, and drives them as registered outputs.
- Two-entry buffer (output register + skid register) absorbs downstream stalls without combinational ready paths.

Parameters:
- DW, 32, operand/data width
- SHW, 5, shift amount width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- flush  in  1  synchronous; drops all held entries
- in_valid  in  1  upstream entry valid
- in_ready  out  1  stage can accept; registered, equals ~skid_valid
- instr  in  32  instruction word
- src1  in  DW  register operand 1
- src2  in  DW  register operand 2
- mem_data  in  DW  memory read data
- out_valid  out  1  output register holds an entry
- out_ready  in  1  downstream accepts this cycle
- aluin1  out  DW  ALU operand 1
- aluin2  out  DW  ALU operand 2
- operation  out  3  instr[2:0]
- opselect  out  3  instr[5:3]
- shift_number  out  SHW  shift amount
- enable_arith  out  1  arith/logic/mem-read enable
- enable_shift  out  1  shift enable

Behaviour:
- Opselect codes: SHIFT_REG 3'b000, ARITH_LOGIC 3'b001, MEM_WRITE 3'b100, MEM_READ 3'b101.
- Instruction fields:
  - operation = instr[2:0]; opselect = instr[5:3]; imm_sel = instr[6].
  - shamt_imm = instr[11:7]; imm16 = instr[31:16].
- Decode, applied when an entry is captured:
  - aluin1 = src1.
  - aluin2 = mem_data if opselect == MEM_READ; otherwise sign-extended imm16 if imm_sel == 1; otherwise src2.
  - shift_number = shamt_imm if imm_sel == 1, else src2[SHW-1:0].
  - enable_shift_raw = (opselect == SHIFT_REG).
  - enable_arith_raw = (opselect == ARITH_LOGIC or MEM_READ).
  - Any other opselect passes through with both raw enables 0.
- Output enable gating: enable_arith = raw & out_valid; enable_shift = raw & out_valid. Both enables are 0 whenever out_valid = 0.
- Transfers: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- States, EMPTY (out_valid=0, skid_valid=0) / ONE (1,0) / FULL (1,1):
  - EMPTY: on in_fire → ONE, decoded entry loads the output register.
  - ONE, in_fire & out_fire: new entry loads the output register, stay ONE.
  - ONE, in_fire & ~out_fire: entry loads skid → FULL.
  - ONE, out_fire only: → EMPTY.
  - FULL: in_ready = 0. On out_fire, skid moves to the output register → ONE.
- Latency: 1 cycle from in_fire to out_valid when EMPTY.
- Ordering: strictly FIFO; no entry is dropped or duplicated except on flush.
- Hold: output fields are held stable while out_valid & ~out_ready.
- Reset (rst=0, async):
  - out_valid = 0, skid_valid = 0, in_ready = 1.
  - aluin1, aluin2, operation, opselect, shift_number, enables all 0.
  - Reset mid-transfer discards everything in flight.
- Flush: next edge → EMPTY; data fields keep old values; enables drop to 0. Flush has priority over a simultaneous in_fire, which is dropped.
- Reset has priority over flush.

Optional Feature:
- Macro STAGE1_STATS_EN.
- Defined:
  - Adds outputs issue_count[31:0] (increments on out_fire) and stall_count[31:0] (increments when out_valid & ~out_ready).
  - Both reset to 0, do not clear on flush, and wrap 32'hFFFFFFFF → 0.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- ALU immediate. Reset, then instr = {16'hFFFE, 9'b0, 1'b1, 3'b001, 3'b000}, src1 = 5, out_ready = 1.
  - Next cycle: out_valid = 1, aluin1 = 5, aluin2 = 32'hFFFFFFFE, enable_arith = 1, enable_shift = 0.
- Shift, register amount. opselect = 000, imm_sel = 0, src2 = 32'h23.
  - shift_number = 5'h03, enable_shift = 1, enable_arith = 0.
- Memory read. opselect = 101, operation = 3'b000, mem_data = 32'h80.
  - aluin2 = 32'h80, enable_arith = 1.
- Backpressure. Hold out_ready = 0, send A, B, then C.
  - A sits on the output, B in skid, in_ready = 0, C is not accepted.
  - Raise out_ready: outputs A, B, C in order on consecutive cycles, and in_ready returns to 1.
- Flush and reset. Assert flush in FULL with in_valid = 1: next cycle out_valid = 0, enables = 0, in_ready = 1.
  - Then drop rst asynchronously mid-cycle: all outputs read 0 immediately.
- STAGE1_STATS_EN. Stall 3 cycles, then deliver 2 entries.
  - stall_count = 3, issue_count = 2.
